axi_read_slave_mem: RTL and testbench
=====================================

Name: axi_read_slave_mem

Overview:
- AXI read-channel responder (slave end) behind AXI_Interconnect's S0/S1 read ports.
- Accepts one AR request at a time, then returns an R burst from an internal word memory.
- Computes FIXED/INCR/WRAP beat addresses, generates RLAST, and flags errors through RRESP.
- Includes a backdoor load port so benches and SoC init logic can preload contents.

Parameters:
- BASE_ADDR, 32'd0, first word address decoded by this slave.
- DEPTH, 16, number of 32-bit words; power of two, 2..1024.
- RD_LATENCY, 0, idle cycles inserted between the AR handshake and the first R beat (0..15).

Ports:
- G_clk  in  1  clock; all logic on the rising edge.
- G_reset  in  1  asynchronous, active-high reset.
- ARADDR  in  32  word address; one address unit = one 32-bit beat.
- ARLEN  in  4  beats-1.
- ARSIZE  in  3  beat size code.
- ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- ARVALID  in  1  request valid.
- ARREADY  out  1  request accepted.
- RVALID  out  1  read beat valid.
- RREADY  in  1  master accepts beat.
- RDATA  out  32  beat data.
- RRESP  out  2  00 OKAY, 10 SLVERR.
- RLAST  out  1  final beat of burst.
- LD_EN  in  1  backdoor write strobe.
- LD_ADDR  in  $clog2(DEPTH)  backdoor word index.
- LD_DATA  in  32  backdoor write data.

Behaviour:
- Reset values (async): ARREADY=0, RVALID=0, RLAST=0, RRESP=00, RDATA=0, state=IDLE. ARREADY rises at the first edge after reset deassertion.
- Memory array is not reset; contents survive reset.
- States:
  - IDLE: ARREADY=1. When ARVALID&ARREADY at an edge, latch addr/len/size/burst and clear the beat counter. Go to WAIT if RD_LATENCY>0; otherwise go to DATA with beat 0 registered on that same edge.
  - WAIT: ARREADY=0. Count RD_LATENCY cycles, then register beat 0 and enter DATA.
  - DATA: ARREADY=0. RVALID=1 with RDATA/RRESP/RLAST stable while RREADY=0.
    - On RVALID&RREADY with a non-last beat: register the next beat on the same edge, so RVALID stays high (full throughput).
    - On RVALID&RREADY with the last beat: RVALID=0 and RLAST=0 on that edge, go to IDLE; ARREADY=1 in the next cycle.
- Latency with RD_LATENCY=0: beat 0 is valid in the cycle immediately after the AR handshake edge. Each extra latency cycle adds exactly one cycle.
- Exactly one outstanding request; ARVALID is ignored outside IDLE.
- Beat count = ARLEN+1 (1..16). RLAST=1 only on beat ARLEN.
- Beat address:
  - FIXED: every beat uses ARADDR.
  - INCR: ARADDR+n, 32-bit wrap.
  - WRAP: boundary = ARLEN+1 words; addr = (ARADDR & ~(ARLEN)) | ((ARADDR+n) & ARLEN).
- Per-beat error: address outside [BASE_ADDR, BASE_ADDR+DEPTH-1] gives RRESP=10 and RDATA=0. In-range beats give RRESP=00 and RDATA=mem[addr-BASE_ADDR].
- Whole-burst errors: every beat gets RRESP=10 and RDATA=0, and the full ARLEN+1 beats are still returned. Causes:
  - ARBURST=11;
  - WRAP with ARLEN not in {1,3,7,15};
  - ARSIZE>3'b010.
- ARSIZE<=3'b010 returns the full 32-bit word.
- Backdoor write: LD_EN writes mem[LD_ADDR] at the edge.
  - Allowed in any state.
  - A beat registered on the same edge as a write to its address returns the old data; later beats see the new data.
- Reset mid-burst: outputs drop to reset values immediately and the burst is abandoned. No RLAST is issued.

Test Plan:
- Preload mem[i]=32'hA0+i, BASE_ADDR=0, RD_LATENCY=0. AR INCR ARADDR=2, ARLEN=1, RREADY=1 -> ARREADY high at handshake. RDATA A2/OKAY then A3/OKAY+RLAST on consecutive cycles; ARREADY high the following cycle.
- WRAP ARADDR=6, ARLEN=3 -> addresses 6,7,4,5; data A6,A7,A4,A5; RLAST on the 4th beat. Repeat with ARLEN=2 -> 3 beats, all RRESP=10, RDATA=0.
- FIXED ARADDR=9, ARLEN=3, RREADY toggling 1,0,1,0,... -> 4 beats of A9; RVALID/RDATA held during RREADY=0; exactly 4 handshakes.
- INCR ARADDR=14, ARLEN=3 (DEPTH=16) -> AE/OKAY, AF/OKAY, then 0/SLVERR twice with RLAST on the last. ARBURST=11 -> all beats SLVERR.
- RD_LATENCY=3; second AR while in DATA with ARVALID held -> first RVALID exactly 4 cycles after the handshake edge. Second request is not accepted until the cycle after the first RLAST handshake.
- Assert G_reset mid-burst (beat 1 of 4) -> RVALID=0 asynchronously, no RLAST. After release, a new burst returns correct preloaded data (memory retained).

Source files
------------

// File: rtl/axi_read_slave_mem.sv
// axi_read_slave_mem: single-outstanding AXI read responder over a backdoor-loadable word memory.
// Supports FIXED/INCR/WRAP bursts, optional first-beat latency, and SLVERR for bad or out-of-range beats.
module axi_read_slave_mem #(
    parameter logic [31:0] BASE_ADDR  = 32'd0,
    parameter int          DEPTH      = 16,
    parameter int          RD_LATENCY = 0
) (
    input  logic                     G_clk,
    input  logic                     G_reset,
    input  logic [31:0]              ARADDR,
    input  logic [3:0]               ARLEN,
    input  logic [2:0]               ARSIZE,
    input  logic [1:0]               ARBURST,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic [31:0]              RDATA,
    output logic [1:0]               RRESP,
    output logic                     RLAST,
    input  logic                     LD_EN,
    input  logic [$clog2(DEPTH)-1:0] LD_ADDR,
    input  logic [31:0]              LD_DATA
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    logic [31:0] mem_q [DEPTH];
    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q;
    logic [3:0]  len_q, beat_q, lat_q;
    logic [1:0]  burst_q;
    logic        err_q;
    logic        arready_q, rvalid_q, rlast_q;
    logic [1:0]  rresp_q;
    logic [31:0] rdata_q;
    logic        ar_hs, r_hs, bad_req, load_beat;
    logic [31:0] cur_addr, len_w, b_addr, b_off, b_data;
    logic [3:0]  cur_len, b_n;
    logic [1:0]  cur_burst;
    logic        cur_err, b_ok;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;
    assign ar_hs   = (state_q == S_IDLE) && arready_q && ARVALID;
    assign r_hs    = rvalid_q && RREADY;
    assign bad_req = (ARBURST == 2'b11) || (ARSIZE > 3'b010) ||
                     ((ARBURST == 2'b10) && !(ARLEN inside {4'd1, 4'd3, 4'd7, 4'd15}));
    // In IDLE the beat is built straight from the AR inputs so beat 0 can register on the handshake edge.
    always_comb begin
        cur_addr  = (state_q == S_IDLE) ? ARADDR  : addr_q;
        cur_len   = (state_q == S_IDLE) ? ARLEN   : len_q;
        cur_burst = (state_q == S_IDLE) ? ARBURST : burst_q;
        cur_err   = (state_q == S_IDLE) ? bad_req : err_q;
        b_n       = (state_q == S_DATA) ? beat_q + 4'd1 : 4'd0;
        len_w     = {28'd0, cur_len};
        b_addr    = (cur_burst == 2'b00) ? cur_addr :
                    (cur_burst == 2'b01) ? cur_addr + {28'd0, b_n} :
                    (cur_addr & ~len_w) | ((cur_addr + {28'd0, b_n}) & len_w);
        b_off     = b_addr - BASE_ADDR;
        b_ok      = !cur_err && (b_addr >= BASE_ADDR) && (b_off < 32'(DEPTH));
        b_data    = b_ok ? mem_q[b_off[AW-1:0]] : 32'd0;
        load_beat = (ar_hs && RD_LATENCY == 0) || (state_q == S_WAIT && lat_q == 4'd0) ||
                    (state_q == S_DATA && r_hs && !rlast_q);
        state_d   = ar_hs ? ((RD_LATENCY == 0) ? S_DATA : S_WAIT) :
                    (state_q == S_WAIT && lat_q == 4'd0) ? S_DATA :
                    (state_q == S_DATA && r_hs && rlast_q) ? S_IDLE : state_q;
    end
    always_ff @(posedge G_clk) begin
        if (LD_EN) mem_q[LD_ADDR] <= LD_DATA;
    end
    always_ff @(posedge G_clk or posedge G_reset) begin
        if (G_reset) begin
            state_q   <= S_IDLE;
            addr_q    <= 32'd0;
            len_q     <= 4'd0;
            burst_q   <= 2'd0;
            err_q     <= 1'b0;
            beat_q    <= 4'd0;
            lat_q     <= 4'd0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE) arready_q <= !ar_hs;
            if (ar_hs) begin
                addr_q  <= ARADDR;
                len_q   <= ARLEN;
                burst_q <= ARBURST;
                err_q   <= bad_req;
                beat_q  <= 4'd0;
                lat_q   <= 4'(RD_LATENCY - 1);
            end
            if (state_q == S_WAIT && lat_q != 4'd0) lat_q <= lat_q - 4'd1;
            if (load_beat) begin
                rvalid_q <= 1'b1;
                rdata_q  <= b_data;
                rresp_q  <= b_ok ? 2'b00 : 2'b10;
                rlast_q  <= (b_n == cur_len);
                beat_q   <= b_n;
            end else if (state_q == S_DATA && r_hs && rlast_q) begin
                rvalid_q  <= 1'b0;
                rlast_q   <= 1'b0;
                arready_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axi_read_slave_mem.sv
// tb_axi_read_slave_mem: directed bursts against a zero-latency and a three-cycle-latency responder.
module tb_axi_read_slave_mem;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = 32'd0;
    logic [3:0]  arlen = 4'd0;
    logic [2:0]  arsize = 3'd2;
    logic [1:0]  arburst = 2'b01;
    logic        arv0 = 1'b0, arv1 = 1'b0, rready = 1'b1;
    logic        ld_en = 1'b0;
    logic [3:0]  ld_addr = 4'd0;
    logic [31:0] ld_data = 32'd0;
    logic        arready0, rvalid0, rlast0, arready1, rvalid1, rlast1;
    logic [31:0] rdata0, rdata1;
    logic [1:0]  rresp0, rresp1;
    logic        sel = 1'b0;
    logic        s_arready, s_rvalid, s_rlast;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    int          n_vec = 0, n_bad = 0;
    logic [31:0] b_dat [16];
    logic [1:0]  b_rsp [16];
    logic        b_lst [16];
    int          b_cyc [16];
    int          nb, hold_bad, ar_busy;
    logic        ar_at_hs, ar_after;

    always #5 clk = ~clk;

    axi_read_slave_mem #(.BASE_ADDR(32'd0), .DEPTH(16), .RD_LATENCY(0)) u_dut0 (
        .G_clk(clk), .G_reset(rst), .ARADDR(araddr), .ARLEN(arlen), .ARSIZE(arsize),
        .ARBURST(arburst), .ARVALID(arv0), .ARREADY(arready0), .RVALID(rvalid0),
        .RREADY(rready), .RDATA(rdata0), .RRESP(rresp0), .RLAST(rlast0),
        .LD_EN(ld_en), .LD_ADDR(ld_addr), .LD_DATA(ld_data));

    axi_read_slave_mem #(.BASE_ADDR(32'd0), .DEPTH(16), .RD_LATENCY(3)) u_dut1 (
        .G_clk(clk), .G_reset(rst), .ARADDR(araddr), .ARLEN(arlen), .ARSIZE(arsize),
        .ARBURST(arburst), .ARVALID(arv1), .ARREADY(arready1), .RVALID(rvalid1),
        .RREADY(rready), .RDATA(rdata1), .RRESP(rresp1), .RLAST(rlast1),
        .LD_EN(ld_en), .LD_ADDR(ld_addr), .LD_DATA(ld_data));

    assign s_arready = sel ? arready1 : arready0;
    assign s_rvalid  = sel ? rvalid1  : rvalid0;
    assign s_rlast   = sel ? rlast1   : rlast0;
    assign s_rdata   = sel ? rdata1   : rdata0;
    assign s_rresp   = sel ? rresp1   : rresp0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic cb(input string tag, input int i, input logic [31:0] d, input logic [1:0] r, input logic l);
        chk({tag, "_data"}, b_dat[i], d);
        chk({tag, "_resp"}, {30'd0, b_rsp[i]}, {30'd0, r});
        chk({tag, "_last"}, {31'd0, b_lst[i]}, {31'd0, l});
    endtask

    // Called on a negedge; cycle 0 is the negedge before the AR handshake edge.
    task automatic run_burst(input logic w, input logic [31:0] a, input logic [3:0] l,
                             input logic [1:0] b, input logic [2:0] sz, input logic tog, input logic keep);
        int cyc;
        logic stall, done;
        logic [31:0] pd;
        nb = 0; hold_bad = 0; ar_busy = 0; stall = 0; done = 0; pd = 0;
        for (int i = 0; i < 16; i++) begin b_dat[i] = 32'hDEAD; b_rsp[i] = 2'b01; b_lst[i] = 1'b0; b_cyc[i] = -1; end
        araddr = a; arlen = l; arburst = b; arsize = sz; rready = 1'b1;
        if (w) arv1 = 1'b1; else arv0 = 1'b1;
        cyc = 0;
        while (!s_arready && cyc < 64) begin @(negedge clk); cyc++; end
        ar_at_hs = s_arready;
        if (!s_arready) chk("ar_timeout", 32'd0, 32'd1);
        cyc = 0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (!keep) begin arv0 = 1'b0; arv1 = 1'b0; end
            rready = tog ? (cyc % 2 == 1) : 1'b1;
            if (stall && (!s_rvalid || s_rdata !== pd)) hold_bad++;
            if (s_arready) ar_busy++;
            if (s_rvalid && rready && nb < 16) begin
                b_dat[nb] = s_rdata; b_rsp[nb] = s_rresp; b_lst[nb] = s_rlast; b_cyc[nb] = cyc;
                nb++;
                done = s_rlast;
            end
            stall = s_rvalid && !rready;
            pd = s_rdata;
        end
        if (!done) chk("r_timeout", 32'd0, 32'd1);
        rready = 1'b1;
        @(negedge clk);
        ar_after = s_arready;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("rst_arready0", {31'd0, arready0}, 32'd0);
        chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("rst_rlast0", {31'd0, rlast0}, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rresp0", {30'd0, rresp0}, 32'd0);
        chk("rst_arready1", {31'd0, arready1}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_addr = 4'(i); ld_data = 32'hA0 + 32'(i);
        end
        @(negedge clk);
        ld_en = 1'b0;
        rst = 1'b0;
        #1 chk("arready_at_release", {31'd0, arready0}, 32'd0);
        @(negedge clk);
        chk("arready_first_edge", {31'd0, arready0}, 32'd1);

        sel = 1'b0;
        run_burst(1'b0, 32'd2, 4'd1, 2'b01, 3'd2, 1'b0, 1'b0);
        chk("incr_ar_hs", {31'd0, ar_at_hs}, 32'd1);
        chk("incr_nb", nb, 2);
        cb("incr_b0", 0, 32'hA2, 2'b00, 1'b0);
        cb("incr_b1", 1, 32'hA3, 2'b00, 1'b1);
        chk("incr_lat", b_cyc[0], 1);
        chk("incr_b2b", b_cyc[1], 2);
        chk("incr_ar_after", {31'd0, ar_after}, 32'd1);

        run_burst(1'b0, 32'd6, 4'd3, 2'b10, 3'd2, 1'b0, 1'b0);
        chk("wrap_nb", nb, 4);
        cb("wrap_b0", 0, 32'hA6, 2'b00, 1'b0);
        cb("wrap_b1", 1, 32'hA7, 2'b00, 1'b0);
        cb("wrap_b2", 2, 32'hA4, 2'b00, 1'b0);
        cb("wrap_b3", 3, 32'hA5, 2'b00, 1'b1);

        run_burst(1'b0, 32'd6, 4'd2, 2'b10, 3'd2, 1'b0, 1'b0);
        chk("wrapbad_nb", nb, 3);
        cb("wrapbad_b0", 0, 32'd0, 2'b10, 1'b0);
        cb("wrapbad_b2", 2, 32'd0, 2'b10, 1'b1);

        run_burst(1'b0, 32'd9, 4'd3, 2'b00, 3'd2, 1'b1, 1'b0);
        chk("fixed_nb", nb, 4);
        cb("fixed_b0", 0, 32'hA9, 2'b00, 1'b0);
        cb("fixed_b1", 1, 32'hA9, 2'b00, 1'b0);
        cb("fixed_b3", 3, 32'hA9, 2'b00, 1'b1);
        chk("fixed_hold", hold_bad, 0);
        chk("fixed_last_cyc", b_cyc[3], 7);

        run_burst(1'b0, 32'd14, 4'd3, 2'b01, 3'd2, 1'b0, 1'b0);
        chk("oor_nb", nb, 4);
        cb("oor_b0", 0, 32'hAE, 2'b00, 1'b0);
        cb("oor_b1", 1, 32'hAF, 2'b00, 1'b0);
        cb("oor_b2", 2, 32'd0, 2'b10, 1'b0);
        cb("oor_b3", 3, 32'd0, 2'b10, 1'b1);

        run_burst(1'b0, 32'd1, 4'd1, 2'b11, 3'd2, 1'b0, 1'b0);
        chk("rsvd_nb", nb, 2);
        cb("rsvd_b0", 0, 32'd0, 2'b10, 1'b0);
        cb("rsvd_b1", 1, 32'd0, 2'b10, 1'b1);

        run_burst(1'b0, 32'd0, 4'd0, 2'b01, 3'd3, 1'b0, 1'b0);
        chk("size_nb", nb, 1);
        cb("size_b0", 0, 32'd0, 2'b10, 1'b1);

        sel = 1'b1;
        run_burst(1'b1, 32'd0, 4'd1, 2'b01, 3'd2, 1'b0, 1'b1);
        chk("lat_first", b_cyc[0], 4);
        chk("lat_nb", nb, 2);
        cb("lat_b0", 0, 32'hA0, 2'b00, 1'b0);
        cb("lat_b1", 1, 32'hA1, 2'b00, 1'b1);
        chk("lat_ar_busy", ar_busy, 0);
        chk("lat_ar_after", {31'd0, ar_after}, 32'd1);
        run_burst(1'b1, 32'd0, 4'd1, 2'b01, 3'd2, 1'b0, 1'b0);
        chk("lat2_first", b_cyc[0], 4);
        cb("lat2_b1", 1, 32'hA1, 2'b00, 1'b1);

        sel = 1'b0;
        araddr = 32'd4; arlen = 4'd3; arburst = 2'b01; arsize = 3'd2; rready = 1'b1;
        arv0 = 1'b1;
        @(negedge clk);
        arv0 = 1'b0;
        chk("mid_b0", rdata0, 32'hA4);
        @(negedge clk);
        chk("mid_b1", rdata0, 32'hA5);
        rst = 1'b1;
        #1;
        chk("mid_rst_rvalid", {31'd0, rvalid0}, 32'd0);
        chk("mid_rst_rlast", {31'd0, rlast0}, 32'd0);
        chk("mid_rst_rdata", rdata0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_arready", {31'd0, arready0}, 32'd1);
        chk("mid_rst_no_rvalid", {31'd0, rvalid0}, 32'd0);
        run_burst(1'b0, 32'd4, 4'd1, 2'b01, 3'd2, 1'b0, 1'b0);
        chk("post_rst_nb", nb, 2);
        cb("post_rst_b0", 0, 32'hA4, 2'b00, 1'b0);
        cb("post_rst_b1", 1, 32'hA5, 2'b00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
